// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - auto-play melody ROM sequencer driving tone generator note keys
// Optional feature macro: MELODY_TEMPO_SEL_EN (adds tempo[1:0] speed select, sampled at song start)
module melody_sequencer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
`ifdef MELODY_TEMPO_SEL_EN
  input  logic [1:0] tempo,
`endif
  output logic [2:0] key_n,
  output logic [1:0] note,
  output logic       busy,
  output logic       done,
  output logic [2:0] step
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW       = $clog2(TICK_DIV * 2);
  localparam logic [TW-1:0] TICK_DIV_W = TW'(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t         state;
  logic [TW-1:0]  tick_cnt;
  logic [3:0]     tick_num;
  logic [3:0]     cur_dur;
  logic [TW-1:0]  tick_len;
  logic [TW-1:0]  tick_last;
  logic           tick_end;
  logic [2:0]     next_idx;
  logic [5:0]     next_entry;
  logic [5:0]     first_entry;
  logic           has_next;

  // Melody table: {note[1:0], dur[3:0]}, dur=0 marks the end of the song
  function automatic logic [5:0] rom_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_entry = {2'd1, 4'd2};
      3'd1:    rom_entry = {2'd2, 4'd2};
      3'd2:    rom_entry = {2'd3, 4'd2};
      3'd3:    rom_entry = {2'd1, 4'd4};
      3'd4:    rom_entry = {2'd0, 4'd2};
      3'd5:    rom_entry = {2'd3, 4'd1};
      default: rom_entry = {2'd0, 4'd0};
    endcase
  endfunction

  // Active-low one-hot key pattern for a note code; rest maps to silence
  function automatic logic [2:0] note_keys(input logic [1:0] n);
    case (n)
      2'd1:    note_keys = 3'b011;
      2'd2:    note_keys = 3'b101;
      2'd3:    note_keys = 3'b110;
      default: note_keys = 3'b111;
    endcase
  endfunction

`ifdef MELODY_TEMPO_SEL_EN
  logic [1:0]    tempo_r;
  logic [TW-1:0] tick_shift;
  // Faster tempos shorten the tick; never let a tick collapse to zero cycles
  always_comb begin
    tick_shift = TICK_DIV_W >> tempo_r;
    tick_len   = (tick_shift == '0) ? TW'(1) : tick_shift;
  end
`else
  assign tick_len = TICK_DIV_W;
`endif

  assign tick_last   = tick_len - TW'(1);
  assign tick_end    = (tick_cnt == tick_last);
  assign next_idx    = step + 3'd1;
  assign next_entry  = rom_entry(next_idx);
  assign first_entry = rom_entry(3'd0);
  assign has_next    = (step != 3'd7) && (next_entry[3:0] != 4'd0);

  // Playback FSM: counts whole ticks per note, then one silent tick, then picks the next entry
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      tick_num <= 4'd0;
      cur_dur  <= 4'd0;
      key_n    <= 3'b111;
      note     <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step     <= 3'd0;
`ifdef MELODY_TEMPO_SEL_EN
      tempo_r  <= 2'd0;
`endif
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        tick_cnt <= '0;
        tick_num <= 4'd0;
        key_n    <= 3'b111;
        note     <= 2'd0;
        busy     <= 1'b0;
        step     <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= PLAY;
              step     <= 3'd0;
              cur_dur  <= first_entry[3:0];
              note     <= first_entry[5:4];
              key_n    <= note_keys(first_entry[5:4]);
              busy     <= 1'b1;
              tick_cnt <= '0;
              tick_num <= 4'd0;
`ifdef MELODY_TEMPO_SEL_EN
              tempo_r  <= tempo;
`endif
            end
          end
          PLAY: begin
            if (tick_end) begin
              tick_cnt <= '0;
              if (tick_num == cur_dur - 4'd1) begin
                state    <= GAP;
                tick_num <= 4'd0;
                note     <= 2'd0;
                key_n    <= 3'b111;
              end else begin
                tick_num <= tick_num + 4'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          GAP: begin
            if (tick_end) begin
              tick_cnt <= '0;
              tick_num <= 4'd0;
              if (has_next) begin
                state   <= PLAY;
                step    <= next_idx;
                cur_dur <= next_entry[3:0];
                note    <= next_entry[5:4];
                key_n   <= note_keys(next_entry[5:4]);
              end else if (loop) begin
                state   <= PLAY;
                step    <= 3'd0;
                cur_dur <= first_entry[3:0];
                note    <= first_entry[5:4];
                key_n   <= note_keys(first_entry[5:4]);
              end else begin
                state   <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                step    <= 3'd0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            key_n <= 3'b111;
            note  <= 2'd0;
            step  <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule
